mem_bus_arbiter: RTL and testbench

Shares the CPU's single Avalon memory-mapped master port between two requesters: the instruction-fetch path and the load/store data path. Each request is latched on grant and issued on the bus, held through `waitrequest` stalls, and completed with a one-cycle done pulse and captured read data on the originating port. The block sits between the PC/instruction register and data memory logic on one side and the top-level `address`/`read`/`write`/`writedata`/`readdata`/`waitrequest` pins on the other.

---
 rtl/mem_bus_if.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if.sv
// mem_bus_if: requester handshakes and Avalon-MM pins of the memory bus arbiter.
//   fetch port : if_req, if_addr -> if_rdata, if_done
//   data port  : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_done
//   Avalon pins: address, read, write, writedata <- waitrequest, readdata
// Modport master is the arbiter side (it masters the Avalon port);
// modport slave is the surrounding environment (requesters + memory).
`timescale 1ns/1ps
interface mem_bus_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, waitrequest, readdata,
        output if_rdata, if_done, dm_rdata, dm_done, address, read, write, writedata
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, waitrequest, readdata,
        input  if_rdata, if_done, dm_rdata, dm_done, address, read, write, writedata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Avalon-MM master port between the instruction
// fetch path and the load/store data path.
//   clk, reset   : single clock, synchronous active-high reset
//   bus          : mem_bus_if.master (requester handshakes + Avalon pins)
//   busy         : high while a transfer is in XFER or DONE
//   timeout_err  : sticky abort flag (only live with MEM_ARB_TIMEOUT_EN)
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort transfers stalled for
// TIMEOUT_CYCLES waitrequest cycles; otherwise XFER waits indefinitely.
`timescale 1ns/1ps
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_if.master        bus,
    output logic             busy,
    output logic             timeout_err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    state_e      state_r;
    state_e      state_nxt_s;
    logic        owner_r;
    logic        last_r;
    logic [31:0] address_r;
    logic [31:0] writedata_r;
    logic [31:0] if_rdata_r;
    logic [31:0] dm_rdata_r;
    logic        read_r;
    logic        write_r;
    logic        if_done_r;
    logic        dm_done_r;

    logic        grant_s;
    logic        grant_data_s;
    logic        finish_s;
    logic        tmo_hit_s;
    logic        read_nxt_s;
    logic        write_nxt_s;
    logic        if_done_nxt_s;
    logic        dm_done_nxt_s;
    logic        cap_if_s;
    logic        cap_dm_s;
    logic [31:0] rdata_nxt_s;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // On a tie the requester that did not win last time is granted.
    assign grant_s      = (state_r == ST_IDLE) && (bus.if_req || bus.dm_req);
    assign grant_data_s = bus.dm_req && (!bus.if_req || (last_r == OWNER_FETCH));
    assign finish_s     = (state_r == ST_XFER) && (!bus.waitrequest || tmo_hit_s);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_r;
    logic             tmo_err_r;

    // Abort on the stall that would bring the count to TIMEOUT_CYCLES.
    assign tmo_hit_s   = (state_r == ST_XFER) && bus.waitrequest && (tmo_cnt_r == TMO_LAST);
    assign timeout_err = tmo_err_r;

    // Stall counter (cleared on grant) and sticky abort flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
            tmo_err_r <= 1'b0;
        end else begin
            if (grant_s) begin
                tmo_cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == ST_XFER) && bus.waitrequest) begin
                tmo_cnt_r <= tmo_cnt_r + 1'b1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
            if (tmo_hit_s) begin
                tmo_err_r <= 1'b1;
            end else begin
                tmo_err_r <= tmo_err_r;
            end
        end
    end
`else
    assign tmo_hit_s   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (finish_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode: next values of the registered strobes and pulses.
    always_comb begin
        read_nxt_s    = 1'b0;
        write_nxt_s   = 1'b0;
        if_done_nxt_s = 1'b0;
        dm_done_nxt_s = 1'b0;
        cap_if_s      = 1'b0;
        cap_dm_s      = 1'b0;
        if (tmo_hit_s) begin
            rdata_nxt_s = 32'h0000_0000;
        end else begin
            rdata_nxt_s = bus.readdata;
        end
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    read_nxt_s  = !grant_data_s || !bus.dm_we;
                    write_nxt_s = grant_data_s && bus.dm_we;
                end else begin
                    read_nxt_s  = 1'b0;
                    write_nxt_s = 1'b0;
                end
            end
            ST_XFER: begin
                if (finish_s) begin
                    if_done_nxt_s = (owner_r == OWNER_FETCH);
                    dm_done_nxt_s = (owner_r == OWNER_DATA);
                    cap_if_s      = read_r && (owner_r == OWNER_FETCH);
                    cap_dm_s      = read_r && (owner_r == OWNER_DATA);
                end else begin
                    read_nxt_s  = read_r;
                    write_nxt_s = write_r;
                end
            end
            ST_DONE: begin
                read_nxt_s  = 1'b0;
                write_nxt_s = 1'b0;
            end
            default: begin
                read_nxt_s  = 1'b0;
                write_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and request-latch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r     <= OWNER_FETCH;
            last_r      <= OWNER_FETCH;
            address_r   <= 32'h0000_0000;
            writedata_r <= 32'h0000_0000;
            if_rdata_r  <= 32'h0000_0000;
            dm_rdata_r  <= 32'h0000_0000;
            read_r      <= 1'b0;
            write_r     <= 1'b0;
            if_done_r   <= 1'b0;
            dm_done_r   <= 1'b0;
        end else begin
            read_r    <= read_nxt_s;
            write_r   <= write_nxt_s;
            if_done_r <= if_done_nxt_s;
            dm_done_r <= dm_done_nxt_s;
            if (grant_s) begin
                owner_r   <= grant_data_s;
                last_r    <= grant_data_s;
                address_r <= grant_data_s ? bus.dm_addr : bus.if_addr;
                if (grant_data_s) begin
                    writedata_r <= bus.dm_wdata;
                end else begin
                    writedata_r <= writedata_r;
                end
            end else begin
                owner_r     <= owner_r;
                last_r      <= last_r;
                address_r   <= address_r;
                writedata_r <= writedata_r;
            end
            if (cap_if_s) begin
                if_rdata_r <= rdata_nxt_s;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            if (cap_dm_s) begin
                dm_rdata_r <= rdata_nxt_s;
            end else begin
                dm_rdata_r <= dm_rdata_r;
            end
        end
    end

    assign bus.address   = address_r;
    assign bus.writedata = writedata_r;
    assign bus.read      = read_r;
    assign bus.write     = write_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.if_done   = if_done_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign bus.dm_done   = dm_done_r;
    assign busy          = (state_r == ST_XFER) || (state_r == ST_DONE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus for mem_bus_arbiter with a
// transaction-level reference model checked every cycle, plus literal
// expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    localparam int TMO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic timeout_err;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    mem_bus_if bus ();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one transaction in flight at a time; who = 0 fetch, 1 data.
    bit          m_xfer, m_done, m_we, m_if_done, m_dm_done, m_tmo_err;
    int          m_who, m_last, m_stalls;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_xfer = 1'b0; m_done = 1'b0; m_we = 1'b0;
                m_if_done = 1'b0; m_dm_done = 1'b0; m_tmo_err = 1'b0;
                m_who = 0; m_last = 0; m_stalls = 0;
                m_addr = 32'h0; m_wdata = 32'h0; m_if_rdata = 32'h0; m_dm_rdata = 32'h0;
            end else if (m_xfer) begin
                if (bus.waitrequest && !(TMO_ON && (m_stalls + 1 == TMO))) begin
                    m_stalls++;
                end else begin
                    if (!m_we) begin
                        if (m_who == 0) m_if_rdata = bus.waitrequest ? 32'h0 : bus.readdata;
                        else            m_dm_rdata = bus.waitrequest ? 32'h0 : bus.readdata;
                    end
                    if (bus.waitrequest) m_tmo_err = 1'b1;
                    m_xfer = 1'b0;
                    m_done = 1'b1;
                    m_if_done = (m_who == 0);
                    m_dm_done = (m_who == 1);
                end
            end else if (m_done) begin
                m_done = 1'b0; m_if_done = 1'b0; m_dm_done = 1'b0;
            end else if (bus.if_req || bus.dm_req) begin
                if (bus.if_req && bus.dm_req) m_who = 1 - m_last;
                else                          m_who = bus.dm_req ? 1 : 0;
                m_last   = m_who;
                m_we     = (m_who == 1) && bus.dm_we;
                m_addr   = (m_who == 1) ? bus.dm_addr : bus.if_addr;
                if (m_who == 1) m_wdata = bus.dm_wdata;
                m_stalls = 0;
                m_xfer   = 1'b1;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk1("read", bus.read, m_xfer && !m_we);
                chk1("write", bus.write, m_xfer && m_we);
                chk1("busy", busy, m_xfer || m_done);
                chk1("if_done", bus.if_done, m_if_done);
                chk1("dm_done", bus.dm_done, m_dm_done);
                chk("if_rdata", bus.if_rdata, m_if_rdata);
                chk("dm_rdata", bus.dm_rdata, m_dm_rdata);
                chk1("timeout_err", timeout_err, m_tmo_err);
                if (m_xfer) chk("address", bus.address, m_addr);
                if (m_xfer && m_we) chk("writedata", bus.writedata, m_wdata);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0; bus.waitrequest = 1'b0; bus.readdata = 32'h0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_address", bus.address, 32'h0);
        chk("rst_writedata", bus.writedata, 32'h0);
        chk1("rst_read", bus.read, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk1("rst_timeout_err", timeout_err, 1'b0);
        reset = 1'b0;
        step();

        // Single fetch, no stall.
        bus.if_req = 1'b1; bus.if_addr = 32'hBFC0_0000; bus.readdata = 32'h2402_0005;
        step();
        chk1("fetch_read", bus.read, 1'b1);
        chk("fetch_addr", bus.address, 32'hBFC0_0000);
        bus.if_addr = 32'hDEAD_BEEF;
        step();
        chk1("fetch_done", bus.if_done, 1'b1);
        chk("fetch_rdata", bus.if_rdata, 32'h2402_0005);
        chk("model_if_rdata", m_if_rdata, 32'h2402_0005);
        bus.if_req = 1'b0; bus.readdata = 32'h0;
        step();
        chk1("fetch_done_once", bus.if_done, 1'b0);
        chk1("fetch_idle", busy, 1'b0);

        // Load to give dm_rdata a known value.
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_2000; bus.readdata = 32'h1122_3344;
        step();
        chk1("load_read", bus.read, 1'b1);
        chk1("load_write", bus.write, 1'b0);
        step();
        chk1("load_done", bus.dm_done, 1'b1);
        chk("load_rdata", bus.dm_rdata, 32'h1122_3344);
        chk("load_if_rdata_kept", bus.if_rdata, 32'h2402_0005);
        bus.dm_req = 1'b0;
        step();

        // Stalled store: 4 stall cycles, write high for 5.
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h0000_1000;
        bus.dm_wdata = 32'hCAFE_F00D; bus.waitrequest = 1'b1; bus.readdata = 32'hFFFF_FFFF;
        step();
        for (int i = 0; i < 4; i++) begin
            chk1("store_write", bus.write, 1'b1);
            chk("store_addr", bus.address, 32'h0000_1000);
            chk("store_data", bus.writedata, 32'hCAFE_F00D);
            if (i == 0) begin
                bus.dm_addr = 32'h0000_9999; bus.dm_wdata = 32'h0;
            end
            step();
        end
        bus.waitrequest = 1'b0;
        chk1("store_write_last", bus.write, 1'b1);
        step();
        chk1("store_done", bus.dm_done, 1'b1);
        chk1("store_write_off", bus.write, 1'b0);
        chk("store_rdata_kept", bus.dm_rdata, 32'h1122_3344);
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        step();

        // Reset mid-transfer.
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_5000; bus.waitrequest = 1'b1;
        step();
        chk1("rmid_read", bus.read, 1'b1);
        step();
        reset = 1'b1;
        step();
        chk1("rmid_read_off", bus.read, 1'b0);
        chk1("rmid_write_off", bus.write, 1'b0);
        chk1("rmid_busy", busy, 1'b0);
        chk("rmid_address", bus.address, 32'h0);
        chk("rmid_dm_rdata", bus.dm_rdata, 32'h0);
        reset = 1'b0; bus.if_req = 1'b0; bus.waitrequest = 1'b0;
        step();
        chk1("rmid_no_done", bus.if_done, 1'b0);
        step();

        // Tie after reset: data first, then fetch.
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_4000;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_3000; bus.readdata = 32'hA5A5_A5A5;
        step();
        chk("tie_first_addr", bus.address, 32'h0000_3000);
        step();
        chk1("tie_dm_done", bus.dm_done, 1'b1);
        chk1("tie_if_not_done", bus.if_done, 1'b0);
        chk("tie_dm_rdata", bus.dm_rdata, 32'hA5A5_A5A5);
        bus.dm_req = 1'b0; bus.readdata = 32'h5A5A_5A5A;
        step();
        step();
        chk("tie_second_addr", bus.address, 32'h0000_4000);
        chk1("tie_second_read", bus.read, 1'b1);
        step();
        chk1("tie_if_done", bus.if_done, 1'b1);
        chk("tie_if_rdata", bus.if_rdata, 32'h5A5A_5A5A);
        bus.if_req = 1'b0;
        step();

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout: load stuck behind waitrequest.
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_6000;
        bus.waitrequest = 1'b1; bus.readdata = 32'h7777_7777;
        step();
        for (int i = 0; i < TMO; i++) begin
            chk1("tmo_read_held", bus.read, 1'b1);
            step();
        end
        chk1("tmo_read_off", bus.read, 1'b0);
        chk1("tmo_done", bus.dm_done, 1'b1);
        chk("tmo_rdata", bus.dm_rdata, 32'h0);
        chk1("tmo_err", timeout_err, 1'b1);
        bus.dm_req = 1'b0; bus.waitrequest = 1'b0;
        step();
        step();
        chk1("tmo_err_sticky", timeout_err, 1'b1);
        reset = 1'b1;
        step();
        chk1("tmo_err_cleared", timeout_err, 1'b0);
        reset = 1'b0;
        step();
`endif

        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
